amo_lrsc_ctrl: RTL
==================

Name: amo_lrsc_ctrl

Overview:
- Sequences RV32A atomic instructions (AMO*, LR.W, SC.W) onto a single-ported data-memory interface and owns the load-reservation register.
- Sits beside the LSU in the execute stage. Accepts one decoded atomic at a time as a 32-bit instruction word (atype layout) plus rs1/rs2 operand values.
- Issues a load and/or a store to memory, then returns the rd writeback value.

Parameters:
- XLEN, 32, operand/data width; only 32 is supported (W-size atomics).
- ADDR_W, 32, memory address width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  atomic request valid.
- req_ready_o  out  1  controller can accept a request.
- req_instr_i  in  32  instruction word, atype fields (funct5, aq, rl, rs2, rs1, funct3, rd, opcode).
- req_addr_i  in  ADDR_W  rs1 value (effective address).
- req_data_i  in  XLEN  rs2 value.
- resp_valid_o  out  1  result valid.
- resp_ready_i  in  1  consumer accepts result.
- resp_data_o  out  XLEN  rd writeback value.
- resp_err_o  out  1  illegal instruction or misaligned address.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_we_o  out  1  1 = store, 0 = load.
- mem_req_addr_o  out  ADDR_W  word address (req_addr_i, latched).
- mem_req_wdata_o  out  XLEN  store data.
- mem_rsp_valid_i  in  1  memory response. Returns load data or a store acknowledgement; exactly one per accepted request.
- mem_rsp_rdata_i  in  XLEN  load data.
- resv_clr_i  in  1  external reservation kill (trap, context switch, snooped store).
- resv_valid_o  out  1  reservation currently held.

Behaviour:
- Reset (async, rst_i=1): state IDLE; reservation cleared. All outputs 0 except req_ready_o=1. All latched instr/addr/data/old-value registers 0.
- req_ready_o = (state==IDLE). A request is accepted on req_valid_i & req_ready_o; instr, addr and rs2 are latched that edge.
- Decode at accept, used for legality checks:
  - Legal only if opcode=0101111 and funct3=010.
  - funct5 must be one of: LR 00010, SC 00011, SWAP 00001, ADD 00000, XOR 00100, AND 01100, OR 01000, MIN 10000, MAX 10100, MINU 11000, MAXU 11100.
  - LR additionally requires rs2 field = 0.
  - aq/rl are accepted and ignored; the memory interface is in-order.
- Illegal or addr[1:0]!=0: go to RESP with resp_err_o=1, resp_data_o=0. No memory access. Reservation unchanged.
- States: IDLE, LD_REQ, LD_WAIT, ALU, ST_REQ, ST_WAIT, RESP.
- LR: IDLE -> LD_REQ -> LD_WAIT.
  - On mem_rsp_valid_i: resv_addr <= addr, resv_valid <= 1, result <= rdata, go to RESP.
- SC:
  - If resv_valid & resv_addr==addr: IDLE -> ST_REQ (wdata=rs2) -> ST_WAIT; on ack, result=0, go to RESP.
  - Otherwise: result=1, go directly to RESP with no memory access.
  - resv_valid is cleared on leaving IDLE for either path.
- AMO: IDLE -> LD_REQ -> LD_WAIT (old <= rdata) -> ALU -> ST_REQ (wdata = f(old, rs2)) -> ST_WAIT -> on ack RESP, result = old.
  - If resv_addr==addr, resv_valid is cleared at the ALU cycle.
- ALU functions:
  - SWAP: rs2. ADD: old+rs2 mod 2^32. XOR, AND, OR: bitwise.
  - MIN/MAX: signed compare. MINU/MAXU: unsigned compare. Ties select old.
- LD_REQ/ST_REQ: mem_req_valid_o=1; we = 0 or 1 respectively; addr and wdata held stable until mem_req_ready_i. Advance to the matching WAIT state on handshake.
- LD_WAIT/ST_WAIT: mem_req_valid_o=0; wait any number of cycles for mem_rsp_valid_i. mem_rsp_valid_i in any other state is ignored.
- RESP: resp_valid_o=1 with resp_data_o/resp_err_o stable until resp_ready_i. Then IDLE; resp_valid_o drops the next cycle. No new request can be accepted in the same cycle as the RESP handshake.
- resv_clr_i:
  - Clears resv_valid the next edge in any state.
  - If it coincides with an LR completion edge, clear wins (resv_valid=0).
  - An in-flight operation is never aborted; only the reservation is affected.
- Minimum latency with 0-wait memory (ready=1, response the cycle after request), accept edge = cycle 0:
  - LR: resp_valid_o at cycle 3.
  - AMO: resp_valid_o at cycle 6.
  - SC-fail / error: resp_valid_o at cycle 1.
- Reset asserted mid-operation: immediate return to reset state. Any pending memory response is dropped by state = IDLE.

Test Plan:
- LR.W addr 0x100, mem returns 0xDEADBEEF -> resp_data_o=0xDEADBEEF, err=0, resv_valid_o=1. Then SC.W 0x100 rs2=0x5 -> store we=1 addr 0x100 wdata 0x5, resp_data_o=0, resv_valid_o=0.
- SC.W 0x100 with no reservation -> no mem_req_valid_o, resp_data_o=1 at cycle 1. LR 0x100, resv_clr_i pulse, SC 0x100 -> resp 1, no store.
- AMOADD addr 0x200, old 0xFFFFFFFF, rs2 0x2 -> store 0x00000001, resp 0xFFFFFFFF. AMOMIN old 0x80000000, rs2 0x1 -> store 0x80000000. AMOMINU same operands -> store 0x1.
- AMOSWAP addr 0x202 -> resp_err_o=1, data 0, no memory traffic. Opcode 0110011 -> err=1. LR with rs2 field=3 -> err=1.
- Backpressure: mem_req_ready_i low 3 cycles, response after 4 cycles, resp_ready_i low 2 cycles -> mem_req_* and resp_* held stable throughout; exactly one load and one store issued.
- rst_i asserted in LD_WAIT, then a stray mem_rsp_valid_i after release -> outputs return to reset values, stray response ignored, next LR completes normally.

Source files
------------

// File: rtl/amo_lrsc_ctrl.sv
// RV32A atomic sequencer: runs LR.W / SC.W / AMO*.W as load and/or store
// transactions on a single-ported data memory and owns the load reservation.
module amo_lrsc_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_instr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [XLEN-1:0]   req_data_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [XLEN-1:0]   resp_data_o,
    output logic              resp_err_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [XLEN-1:0]   mem_req_wdata_o,
    input  logic              mem_rsp_valid_i,
    input  logic [XLEN-1:0]   mem_rsp_rdata_i,
    input  logic              resv_clr_i,
    output logic              resv_valid_o
);

    localparam logic [6:0] OPC_AMO  = 7'b0101111;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [4:0] F5_LR    = 5'b00010;
    localparam logic [4:0] F5_SC    = 5'b00011;
    localparam logic [4:0] F5_SWAP  = 5'b00001;
    localparam logic [4:0] F5_ADD   = 5'b00000;
    localparam logic [4:0] F5_XOR   = 5'b00100;
    localparam logic [4:0] F5_AND   = 5'b01100;
    localparam logic [4:0] F5_OR    = 5'b01000;
    localparam logic [4:0] F5_MIN   = 5'b10000;
    localparam logic [4:0] F5_MAX   = 5'b10100;
    localparam logic [4:0] F5_MINU  = 5'b11000;
    localparam logic [4:0] F5_MAXU  = 5'b11100;

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ALU,
        ST_REQ,
        ST_WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [31:0]        instr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [XLEN-1:0]    data_q;
    logic [XLEN-1:0]    old_q;
    logic               resv_valid;
    logic [ADDR_W-1:0]  resv_addr;

    logic [4:0]         req_f5;
    logic               req_f5_ok;
    logic               req_legal;
    logic               req_misaligned;
    logic               req_is_sc;
    logic [4:0]         op_f5;
    logic               op_is_lr;
    logic               op_is_sc;
    logic [XLEN-1:0]    alu_result;
    logic               unused_instr_bits;

    assign req_f5         = req_instr_i[31:27];
    assign req_is_sc      = (req_f5 == F5_SC);
    assign req_misaligned = |req_addr_i[1:0];

    always_comb begin
        req_f5_ok = 1'b0;
        case (req_f5)
            F5_LR, F5_SC, F5_SWAP, F5_ADD, F5_XOR, F5_AND,
            F5_OR, F5_MIN, F5_MAX, F5_MINU, F5_MAXU: req_f5_ok = 1'b1;
            default:                                 req_f5_ok = 1'b0;
        endcase
    end

    // LR has no source data, so a nonzero rs2 field is a reserved encoding.
    assign req_legal = (req_instr_i[6:0] == OPC_AMO) &&
                       (req_instr_i[14:12] == F3_WORD) &&
                       req_f5_ok &&
                       ((req_f5 != F5_LR) || (req_instr_i[24:20] == 5'd0));

    assign op_f5    = instr_q[31:27];
    assign op_is_lr = (op_f5 == F5_LR);
    assign op_is_sc = (op_f5 == F5_SC);

    // Only funct5 of the latched word matters once the request is accepted.
    assign unused_instr_bits = ^instr_q[26:0];

    // Ties in the min/max family keep the value already in memory.
    always_comb begin
        alu_result = '0;
        case (op_f5)
            F5_SWAP: alu_result = data_q;
            F5_ADD:  alu_result = old_q + data_q;
            F5_XOR:  alu_result = old_q ^ data_q;
            F5_AND:  alu_result = old_q & data_q;
            F5_OR:   alu_result = old_q | data_q;
            F5_MIN:  alu_result = ($signed(old_q) <= $signed(data_q)) ? old_q : data_q;
            F5_MAX:  alu_result = ($signed(old_q) >= $signed(data_q)) ? old_q : data_q;
            F5_MINU: alu_result = (old_q <= data_q) ? old_q : data_q;
            F5_MAXU: alu_result = (old_q >= data_q) ? old_q : data_q;
            default: alu_result = '0;
        endcase
    end

    assign mem_req_addr_o = addr_q;
    assign resv_valid_o   = resv_valid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            req_ready_o     <= 1'b1;
            resp_valid_o    <= 1'b0;
            resp_data_o     <= '0;
            resp_err_o      <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_we_o    <= 1'b0;
            mem_req_wdata_o <= '0;
            instr_q         <= '0;
            addr_q          <= '0;
            data_q          <= '0;
            old_q           <= '0;
            resv_valid      <= 1'b0;
            resv_addr       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        instr_q     <= req_instr_i;
                        addr_q      <= req_addr_i;
                        data_q      <= req_data_i;
                        req_ready_o <= 1'b0;
                        resp_err_o  <= 1'b0;
                        if (!req_legal || req_misaligned) begin
                            resp_err_o   <= 1'b1;
                            resp_data_o  <= '0;
                            resp_valid_o <= 1'b1;
                            state        <= RESP;
                        end else if (req_is_sc) begin
                            // The reservation is consumed whether or not the SC succeeds.
                            resv_valid <= 1'b0;
                            if (resv_valid && (resv_addr == req_addr_i)) begin
                                mem_req_valid_o <= 1'b1;
                                mem_req_we_o    <= 1'b1;
                                mem_req_wdata_o <= req_data_i;
                                state           <= ST_REQ;
                            end else begin
                                resp_data_o  <= XLEN'(1);
                                resp_valid_o <= 1'b1;
                                state        <= RESP;
                            end
                        end else begin
                            mem_req_valid_o <= 1'b1;
                            mem_req_we_o    <= 1'b0;
                            state           <= LD_REQ;
                        end
                    end
                end
                LD_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        if (op_is_lr) begin
                            resv_addr    <= addr_q;
                            resv_valid   <= 1'b1;
                            resp_data_o  <= mem_rsp_rdata_i;
                            resp_valid_o <= 1'b1;
                            state        <= RESP;
                        end else begin
                            old_q <= mem_rsp_rdata_i;
                            state <= ALU;
                        end
                    end
                end
                ALU: begin
                    mem_req_valid_o <= 1'b1;
                    mem_req_we_o    <= 1'b1;
                    mem_req_wdata_o <= alu_result;
                    if (resv_addr == addr_q) begin
                        resv_valid <= 1'b0;
                    end
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        resp_data_o  <= op_is_sc ? '0 : old_q;
                        resp_valid_o <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        req_ready_o  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            // External kill overrides any reservation update made above, including LR completion.
            if (resv_clr_i) begin
                resv_valid <= 1'b0;
            end
        end
    end

endmodule
